exe_stage: RTL

Execute stage of the 5-stage pipeline, consuming the ID/EX pipeline register outputs and producing the registered EX/MEM pipeline register. It contains operand forwarding, the ALUSrc mux, a single-cycle ALU and a 32-cycle iterative shift-add multiplier. While the multiplier runs, the block stalls the upstream stages.

---
 rtl/exe_pkg.sv | 42 ++++
 rtl/exe_if.sv | 48 ++++
 rtl/seq_multiplier.sv | 58 +++++
 rtl/exe_stage.sv | 91 +++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, multiplier
// iteration count, FSM state type and the operand forwarding helper.
package exe_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_NOR = 3'b110;
    localparam logic [2:0] ALU_MUL = 3'b111;

    localparam int MUL_ITER = 32;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } mul_state_t;

    // EX/MEM result wins over MEM/WB; r0 is never forwarded.
    function automatic logic [31:0] fwd_sel(
        input logic [4:0]  src,
        input logic [31:0] rf,
        input logic        mem_wb,
        input logic [4:0]  mem_rd,
        input logic [31:0] mem_d,
        input logic        wb_wb,
        input logic [4:0]  wb_rd,
        input logic [31:0] wb_d
    );
        logic [31:0] r;
        r = rf;
        if (mem_wb && src != 5'd0 && mem_rd == src)
            r = mem_d;
        else if (wb_wb && src != 5'd0 && wb_rd == src)
            r = wb_d;
        return r;
    endfunction

endpackage

// File: rtl/exe_if.sv
// ID/EX inputs, forwarding taps and EX/MEM outputs of the execute stage.
interface exe_if;
    logic        memReadIn;
    logic        memWriteIn;
    logic        writeBackIn;
    logic        ALUSrcIn;
    logic [2:0]  aluOpIn;
    logic [4:0]  destRegIn;
    logic [4:0]  src1RegIn;
    logic [4:0]  src2RegIn;
    logic [31:0] readData1In;
    logic [31:0] readData2In;
    logic [31:0] SEIn;
    logic        memFwdWriteBack;
    logic [4:0]  memFwdDestReg;
    logic [31:0] memFwdData;
    logic        wbFwdWriteBack;
    logic [4:0]  wbFwdDestReg;
    logic [31:0] wbFwdData;
    logic        memReadOut;
    logic        memWriteOut;
    logic        writeBackOut;
    logic [4:0]  destRegOut;
    logic [31:0] aluResultOut;
    logic [31:0] storeDataOut;
    logic        stallOut;
    logic        busyOut;

    modport master (
        output memReadIn, memWriteIn, writeBackIn, ALUSrcIn, aluOpIn,
        output destRegIn, src1RegIn, src2RegIn,
        output readData1In, readData2In, SEIn,
        output memFwdWriteBack, memFwdDestReg, memFwdData,
        output wbFwdWriteBack, wbFwdDestReg, wbFwdData,
        input  memReadOut, memWriteOut, writeBackOut, destRegOut,
        input  aluResultOut, storeDataOut, stallOut, busyOut
    );

    modport slave (
        input  memReadIn, memWriteIn, writeBackIn, ALUSrcIn, aluOpIn,
        input  destRegIn, src1RegIn, src2RegIn,
        input  readData1In, readData2In, SEIn,
        input  memFwdWriteBack, memFwdDestReg, memFwdData,
        input  wbFwdWriteBack, wbFwdDestReg, wbFwdData,
        output memReadOut, memWriteOut, writeBackOut, destRegOut,
        output aluResultOut, storeDataOut, stallOut, busyOut
    );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per cycle,
// low 32 bits of the product kept.
module seq_multiplier
    import exe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);
    mul_state_t  state, next;
    logic [4:0]  cnt;
    logic [31:0] mcand, mplier, acc;
    logic        busy_q;

    always_comb begin
        next = state;
        unique case (state)
            IDLE: if (start) next = MUL;
            MUL:  if (cnt == 5'(MUL_ITER - 1)) next = DONE;
            DONE: next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else begin
            state  <= next;
            busy_q <= (next != IDLE);
            if (state == IDLE && start) begin
                mcand  <= a;
                mplier <= b;
                acc    <= '0;
                cnt    <= '0;
            end else if (state == MUL) begin
                if (mplier[0]) acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 5'd1;
            end
        end
    end

    assign busy    = busy_q;
    assign done    = (state == DONE);
    assign product = acc;
endmodule

// File: rtl/exe_stage.sv
// Execute stage: forwarding (EXE_FWD_EN), ALUSrc mux, ALU, iterative
// multiplier with upstream stall, and the EX/MEM pipeline register.
module exe_stage
    import exe_pkg::*;
(
    input  logic clk,
    input  logic rst,
    exe_if.slave bus
);
    logic [31:0] op_a, src2_val, op_b, alu_res, product;
    logic        busy, done, is_mul, stall;

`ifdef EXE_FWD_EN
    assign op_a = fwd_sel(bus.src1RegIn, bus.readData1In,
                          bus.memFwdWriteBack, bus.memFwdDestReg,
                          bus.memFwdData, bus.wbFwdWriteBack,
                          bus.wbFwdDestReg, bus.wbFwdData);
    assign src2_val = fwd_sel(bus.src2RegIn, bus.readData2In,
                              bus.memFwdWriteBack, bus.memFwdDestReg,
                              bus.memFwdData, bus.wbFwdWriteBack,
                              bus.wbFwdDestReg, bus.wbFwdData);
`else
    logic unused_fwd;
    assign unused_fwd = ^{bus.src1RegIn, bus.src2RegIn,
                          bus.memFwdWriteBack, bus.memFwdDestReg,
                          bus.memFwdData, bus.wbFwdWriteBack,
                          bus.wbFwdDestReg, bus.wbFwdData};
    assign op_a     = bus.readData1In;
    assign src2_val = bus.readData2In;
`endif

    assign op_b = bus.ALUSrcIn ? bus.SEIn : src2_val;

    always_comb begin
        alu_res = '0;
        unique case (bus.aluOpIn)
            ALU_ADD: alu_res = op_a + op_b;
            ALU_SUB: alu_res = op_a - op_b;
            ALU_AND: alu_res = op_a & op_b;
            ALU_OR:  alu_res = op_a | op_b;
            ALU_SLT: alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
            ALU_XOR: alu_res = op_a ^ op_b;
            ALU_NOR: alu_res = ~(op_a | op_b);
            ALU_MUL: alu_res = '0;
            default: alu_res = '0;
        endcase
    end

    assign is_mul = (bus.aluOpIn == ALU_MUL);

    seq_multiplier u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (is_mul),
        .a       (op_a),
        .b       (op_b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    // Stall while issuing or iterating; released in DONE.
    assign stall        = rst & ((is_mul & ~busy) | (busy & ~done));
    assign bus.stallOut = stall;
    assign bus.busyOut  = busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.memReadOut   <= 1'b0;
            bus.memWriteOut  <= 1'b0;
            bus.writeBackOut <= 1'b0;
            bus.destRegOut   <= '0;
            bus.aluResultOut <= '0;
            bus.storeDataOut <= '0;
        end else if (stall) begin
            bus.memReadOut   <= 1'b0;
            bus.memWriteOut  <= 1'b0;
            bus.writeBackOut <= 1'b0;
            bus.destRegOut   <= '0;
            bus.aluResultOut <= '0;
            bus.storeDataOut <= '0;
        end else begin
            bus.memReadOut   <= bus.memReadIn;
            bus.memWriteOut  <= bus.memWriteIn;
            bus.writeBackOut <= bus.writeBackIn;
            bus.destRegOut   <= bus.destRegIn;
            bus.aluResultOut <= done ? product : alu_res;
            bus.storeDataOut <= src2_val;
        end
    end
endmodule
